// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the decoupled instruction-fetch front end.
package fetch_queue_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
   localparam int          PC_STEP_DEFAULT  = 4;
   localparam logic [31:0] NOP_WORD         = 32'h0;

   // Counter width able to hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush, occupancy count and full/empty flags.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!reset && !flush) assert (!(push && !do_push));
   end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: credit-limited imem issue, in-flight PC tracking, decode queue.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
   parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic            dq_valid,
   input  logic            dq_ready,
   output logic [XLEN-1:0] dq_instr,
   output logic [XLEN-1:0] dq_pc_next
);

   localparam int CW = cnt_w(DEPTH);

   logic [XLEN-1:0]   fetch_pc;
   logic [XLEN-1:0]   pf_head;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     drop;
   logic [CW-1:0]     q_count;
   logic [CW-1:0]     pf_count_unused;
   logic              pf_full_unused;
   logic              pf_empty_unused;
   logic              q_full_unused;
   logic              q_empty;
   logic [2*XLEN-1:0] q_head;
   logic [2*XLEN-1:0] q_push_data;
   logic [XLEN-1:0]   head_instr;
   logic [XLEN-1:0]   head_pc_next;
   logic [CW:0]       occupancy;
   logic              accept;
   logic              resp_keep;
   logic              head_valid;
   logic              q_push;
   logic              q_pop;

   // Buffered plus in-flight words may never exceed DEPTH, so a push always finds room.
   assign occupancy      = {1'b0, q_count} + {1'b0, inflight};
   assign imem_req_valid = !reset && !redirect && (occupancy < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign accept         = imem_req_valid && imem_req_ready;
   assign resp_keep      = imem_resp_valid && (drop == '0) && !redirect;
   assign q_push_data    = {pf_head + XLEN'(PC_STEP), imem_resp_data};
   assign head_valid     = !q_empty && !redirect && !reset;
   assign head_instr     = q_empty ? XLEN'(NOP_WORD) : q_head[XLEN-1:0];
   assign head_pc_next   = q_empty ? '0 : q_head[2*XLEN-1:XLEN];
   assign q_pop          = head_valid && dq_ready;

`ifdef FETCH_BYPASS_EN
   logic bypass;
   assign bypass     = q_empty && resp_keep && !reset;
   assign dq_valid   = head_valid || bypass;
   assign dq_instr   = bypass ? imem_resp_data : head_instr;
   assign dq_pc_next = bypass ? q_push_data[2*XLEN-1:XLEN] : head_pc_next;
   assign q_push     = resp_keep && !(bypass && dq_ready);
`else
   assign dq_valid   = head_valid;
   assign dq_instr   = head_instr;
   assign dq_pc_next = head_pc_next;
   assign q_push     = resp_keep;
`endif

   // A redirect turns every still-outstanding request into one to be discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else begin
         inflight <= inflight + CW'(accept) - CW'(imem_resp_valid);
         if (redirect) begin
            fetch_pc <= redirect_pc;
            drop     <= inflight - CW'(imem_resp_valid);
         end else begin
            if (accept) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            if (imem_resp_valid && drop != '0) drop <= drop - 1'b1;
         end
      end
   end

   fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (accept),
      .push_data (fetch_pc),
      .pop       (imem_resp_valid),
      .flush     (1'b0),
      .head      (pf_head),
      .count     (pf_count_unused),
      .full      (pf_full_unused),
      .empty     (pf_empty_unused)
   );

   fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (q_push),
      .push_data (q_push_data),
      .pop       (q_pop),
      .flush     (redirect),
      .head      (q_head),
      .count     (q_count),
      .full      (q_full_unused),
      .empty     (q_empty)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: random imem/decode timing against a queue-based reference model.
module tb_fetch_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [XLEN-1:0] imem_resp_data;
   logic            dq_valid;
   logic            dq_ready;
   logic [XLEN-1:0] dq_instr;
   logic [XLEN-1:0] dq_pc_next;

   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .dq_valid        (dq_valid),
      .dq_ready        (dq_ready),
      .dq_instr        (dq_instr),
      .dq_pc_next      (dq_pc_next)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;

   req_t        imem_q[$];
   logic [31:0] buf_q[$];
   logic [31:0] next_pc;
   int          epoch;
   int          cyc;
   int          n_assert;
   int          n_fail;
   int          rdy_pct;
   int          dqr_pct;
   int          lat_min;
   int          lat_max;
   int          accepts;
   int          pops;
   logic [31:0] last_pop_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit rst, input bit rd, input logic [31:0] rpc);
      bit          resp_now, keep, byp, exp_rv, exp_dv, acc, pop;
      logic [31:0] exp_i, exp_pn;
      req_t        r;
      @(negedge clk);
      resp_now        = !rst && imem_q.size() > 0 && imem_q[0].due <= cyc;
      reset           = rst;
      redirect        = rd;
      redirect_pc     = rpc;
      imem_resp_valid = resp_now;
      imem_resp_data  = resp_now ? ~imem_q[0].addr : $urandom;
      imem_req_ready  = ($urandom_range(99) < rdy_pct);
      dq_ready        = ($urandom_range(99) < dqr_pct);
      #1;
      keep   = resp_now && imem_q[0].epoch == epoch && !rd;
      exp_rv = !rst && !rd && (imem_q.size() + buf_q.size() < DEPTH);
      byp    = 1'b0;
`ifdef FETCH_BYPASS_EN
      byp    = !rst && buf_q.size() == 0 && keep;
`endif
      exp_dv = (!rst && !rd && buf_q.size() > 0) || byp;
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      chk("dq_valid", 32'(dq_valid), 32'(exp_dv));
      if (!rst) begin
         chk("req_addr", imem_req_addr, next_pc);
         if (byp) begin
            exp_i  = ~imem_q[0].addr;
            exp_pn = imem_q[0].addr + 32'd4;
         end else if (buf_q.size() > 0) begin
            exp_i  = ~buf_q[0];
            exp_pn = buf_q[0] + 32'd4;
         end else begin
            exp_i  = 32'h0;
            exp_pn = 32'h0;
         end
         chk("dq_instr", dq_instr, exp_i);
         chk("dq_pc_next", dq_pc_next, exp_pn);
      end
      acc = exp_rv && imem_req_ready;
      pop = exp_dv && dq_ready;
      @(posedge clk);
      if (rst) begin
         imem_q.delete();
         buf_q.delete();
         next_pc = 32'h0;
      end else begin
         if (resp_now) r = imem_q.pop_front();
         if (pop) begin
            pops++;
            if (byp) last_pop_pc = r.addr;
            else begin
               last_pop_pc = buf_q[0];
               buf_q.delete(0);
            end
         end
         if (keep && !(byp && dq_ready)) buf_q.push_back(r.addr);
         if (acc) begin
            imem_q.push_back('{next_pc, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
            next_pc = next_pc + 32'd4;
            accepts++;
         end
         if (rd) begin
            buf_q.delete();
            epoch++;
            next_pc = rpc;
         end
      end
      cyc++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0, a0, t;
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; dq_ready = 1'b0;
      n_assert = 0; n_fail = 0; cyc = 0; epoch = 0; accepts = 0; pops = 0;
      next_pc = 32'h0; last_pop_pc = 32'h0;
      rdy_pct = 100; dqr_pct = 100; lat_min = 1; lat_max = 1;

      step(1, 0, 0);
      step(1, 0, 0);

      // Sequential streaming with a 1-cycle imem.
      repeat (10) step(0, 0, 0);
      p0 = pops;
      repeat (10) step(0, 0, 0);
      chk("throughput", 32'(pops - p0), 32'd10);

      // Decode stall: drain, then exactly DEPTH accepts while decode holds off.
      rdy_pct = 0;
      repeat (6) step(0, 0, 0);
      rdy_pct = 100; dqr_pct = 0;
      a0 = accepts;
      repeat (10) step(0, 0, 0);
      chk("stall_accepts", 32'(accepts - a0), 32'(DEPTH));
      dqr_pct = 100;
      repeat (10) step(0, 0, 0);

      // Redirect with three requests in flight on a 3-cycle imem.
      lat_min = 3; lat_max = 3;
      t = 0;
      while (imem_q.size() != 3 && t < 20) begin step(0, 0, 0); t++; end
      chk("inflight3", 32'(imem_q.size()), 32'd3);
      step(0, 1, 32'h100);
      p0 = pops; t = 0;
      while (pops == p0 && t < 30) begin step(0, 0, 0); t++; end
      chk("redir_first_pc", last_pop_pc, 32'h100);
      repeat (5) step(0, 0, 0);

      // Redirect coinciding with a response.
      lat_min = 2; lat_max = 2;
      t = 0;
      while (!(imem_q.size() >= 2 && imem_q[0].due <= cyc) && t < 20) begin step(0, 0, 0); t++; end
      chk("resp_coincide", 32'(imem_q.size() >= 2 && imem_q[0].due <= cyc), 32'd1);
      step(0, 1, 32'h200);
      repeat (10) step(0, 0, 0);

      // Address wrap at the top of the address space.
      lat_min = 1; lat_max = 1;
      step(0, 1, 32'hFFFF_FFF8);
      p0 = pops; t = 0;
      while (!(pops > p0 && last_pop_pc == 32'hFFFF_FFFC) && t < 30) begin step(0, 0, 0); t++; end
      chk("wrap_seen", last_pop_pc, 32'hFFFF_FFFC);
      repeat (4) step(0, 0, 0);

      // Single response into an empty queue (bypass timing).
      rdy_pct = 0;
      repeat (5) step(0, 0, 0);
      rdy_pct = 100;
      step(0, 0, 0);
      rdy_pct = 0;
      repeat (4) step(0, 0, 0);

      // Randomized traffic with occasional redirects.
      repeat (400) begin
         rdy_pct = int'($urandom_range(100, 40));
         dqr_pct = int'($urandom_range(100, 30));
         lat_min = 1;
         lat_max = int'($urandom_range(4, 1));
         if ($urandom_range(99) < 5) step(0, 1, {$urandom_range(32'h3FFF_FFFF), 2'b00});
         else step(0, 0, 0);
      end
      rdy_pct = 100; dqr_pct = 100;
      repeat (20) step(0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
